// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and buffer payload for the instruction fetch unit.
//   INSTR_W / ADDR_W : instruction word and byte-address widths
//   PC_STEP          : byte increment between sequential fetches
//   fetch_state_e    : FETCH (fetching) / HALTED (fetch stopped, buffer drains)
//   fetch_entry_t    : one buffered instruction with the address it came from
package fetch_pkg;

    localparam int unsigned INSTR_W = 18;
    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Clear the byte offset so the address names a whole instruction word.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: small power-of-two FIFO with synchronous clear.
//   clk     : clock, all updates on rising edge
//   i_clear : synchronous flush (reset or redirect); overrides push/pop
//   i_push  : write i_data; accepted when not full or when popping same cycle
//   i_data  : entry to write
//   i_pop   : remove head entry; ignored when empty
//   o_data  : head entry, all zeros when empty
//   o_full  : occupancy == DEPTH
//   o_empty : occupancy == 0
module instr_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // A full buffer may still take a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!i_clear && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a PC through a combinational-read
// instruction memory, buffers {instr, pc} pairs for the decoder, and handles
// redirects (branch/jump) and halt requests.
//   clk, reset      : clock and synchronous active-high reset
//   imem_addr       : word-aligned fetch address (registered PC)
//   imem_rd         : instruction word for imem_addr, same cycle
//   redirect        : load redirect_pc and flush the buffer
//   redirect_pc     : redirect target byte address
//   halt            : level request to stop fetching
//   out_valid       : head entry present on out_instr / out_pc
//   out_ready       : consumer takes the head entry this cycle
//   out_instr       : head instruction (zero when buffer empty)
//   out_pc          : head instruction address (zero when buffer empty)
//   halted          : stopped and fully drained
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 18'h00000,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    logic [ADDR_W-1:0] r_pc;
    fetch_state_e      r_state;

    logic              w_fifo_clear;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_rd_entry;

    // Redirect beats everything except reset; halt stops the push immediately.
    assign w_fifo_clear = reset || redirect;
    assign w_pop        = out_ready && !w_empty && !redirect;
    assign w_push       = (r_state == FETCH) && !halt && !redirect
                          && (!w_full || w_pop);

    assign w_wr_entry.instr = imem_rd;
    assign w_wr_entry.pc    = r_pc;

    // PC and fetch state; PC wraps modulo 2^ADDR_W on increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= word_align(RESET_PC);
            r_state <= FETCH;
        end else begin
            if (redirect) begin
                r_pc <= word_align(redirect_pc);
            end else if (w_push) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end

            case (r_state)
                FETCH:   if (halt)  r_state <= HALTED;
                HALTED:  if (!halt) r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .i_clear (w_fifo_clear),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Only registered PC reaches the memory address.
    assign imem_addr = word_align(r_pc);

    assign out_valid = !w_empty;
    assign out_instr = w_rd_entry.instr;
    assign out_pc    = w_rd_entry.pc;
    assign halted    = (r_state == HALTED) && w_empty;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table of per-cycle inputs and
// expected outputs, then a streaming sequence and a halt/resume sequence.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] imem_addr;
    logic [17:0] imem_rd;
    logic        redirect;
    logic [17:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_instr;
    logic [17:0] out_pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory contents: word at byte address a is a fixed scramble of a.
    function automatic logic [17:0] mem_word(input logic [17:0] a);
        return {a[17:2], 2'b00} ^ 18'h2B6D5;
    endfunction

    assign imem_rd = mem_word(imem_addr);

    fetch_controller #(
        .RESET_PC   (18'h00000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [17:0] rpc;
        logic        hlt;
        logic        rdy;
        logic        e_valid;
        logic [17:0] e_pc;
        logic [17:0] e_addr;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [17:0] rpc,
                                input logic hlt, input logic rdy, input logic e_valid,
                                input logic [17:0] e_pc, input logic [17:0] e_addr,
                                input logic e_halted);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_addr = e_addr; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] exp_next;
    logic [17:0] e_instr;
    bit          seen;

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;

        // rst redir rpc halt rdy | valid pc addr halted
        // reset, then free-running stream
        vecs.push_back(mk(1, 0, 18'h0,     0, 1, 0, 18'h0,     18'h0,     0));
        vecs.push_back(mk(1, 0, 18'h0,     0, 1, 0, 18'h0,     18'h0,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h0,     18'h4,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h4,     18'h8,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h8,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'hC,     18'h10,    0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h10,    18'h14,    0));
        // stalled consumer fills the buffer, then drains with no gap
        vecs.push_back(mk(1, 0, 18'h0,     0, 0, 0, 18'h0,     18'h0,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h0,     18'h4,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h0,     18'h8,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h0,     18'h8,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h0,     18'h8,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h0,     18'h8,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h4,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h8,     18'h10,    0));
        // redirect to unaligned target with two entries buffered
        vecs.push_back(mk(0, 1, 18'hE,     0, 1, 0, 18'h0,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'hC,     18'h10,    0));
        // PC wrap at top of address space
        vecs.push_back(mk(0, 1, 18'h3FFF8, 0, 1, 0, 18'h0,     18'h3FFF8, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h3FFF8, 18'h3FFFC, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h3FFFC, 18'h0,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h0,     18'h4,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h4,     18'h8,     0));
        // halt with two entries: drain, halted, frozen address, resume
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h4,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     1, 1, 1, 18'h8,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     1, 1, 0, 18'h0,     18'hC,     1));
        vecs.push_back(mk(0, 0, 18'h0,     1, 1, 0, 18'h0,     18'hC,     1));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 0, 18'h0,     18'hC,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'hC,     18'h10,    0));
        // redirect while halted: flush, load PC, stay halted
        vecs.push_back(mk(0, 0, 18'h0,     1, 0, 1, 18'hC,     18'h10,    0));
        vecs.push_back(mk(0, 1, 18'h41,    1, 0, 0, 18'h0,     18'h40,    1));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 0, 18'h0,     18'h40,    0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h40,    18'h44,    0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 1, 18'h40,    18'h48,    0));
        // reset with redirect, halt and pop on a full buffer
        vecs.push_back(mk(1, 1, 18'h100,   1, 1, 0, 18'h0,     18'h0,     0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 1, 18'h0,     18'h4,     0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            halt        = vecs[i].hlt;
            out_ready   = vecs[i].rdy;
            tick();
            e_instr = vecs[i].e_valid ? mem_word(vecs[i].e_pc) : 18'h0;
            check($sformatf("v%0d out_valid", i), 18'(out_valid), 18'(vecs[i].e_valid));
            check($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
            check($sformatf("v%0d out_instr", i), out_instr, e_instr);
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d halted", i), 18'(halted), 18'(vecs[i].e_halted));
        end

        // Streaming with an irregular consumer: in-order pcs, buffer never runs dry.
        reset = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        exp_next = 18'h0;
        for (int c = 0; c < 200; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            check($sformatf("stream c%0d out_valid", c), 18'(out_valid), 18'h1);
            if (out_ready) begin
                check($sformatf("stream c%0d out_pc", c), out_pc, exp_next);
                check($sformatf("stream c%0d out_instr", c), out_instr, mem_word(exp_next));
                exp_next = exp_next + 18'd4;
            end
            tick();
        end

        // Halt mid-stream: buffered entries drain in order, then halted within budget.
        halt = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (halted) begin
                seen = 1'b1;
            end else begin
                if (out_valid) begin
                    check($sformatf("drain c%0d out_pc", c), out_pc, exp_next);
                    exp_next = exp_next + 18'd4;
                end
                tick();
            end
        end
        check("halt reached halted", 18'(seen), 18'h1);
        check("halt frozen imem_addr", imem_addr, exp_next);
        tick();
        check("halt still frozen imem_addr", imem_addr, exp_next);
        halt = 1'b0;
        tick();
        check("resume halted cleared", 18'(halted), 18'h0);
        tick();
        check("resume out_valid", 18'(out_valid), 18'h1);
        check("resume out_pc", out_pc, exp_next);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
